// File: rtl/bec_seq_pkg.sv
// rtl/bec_seq_pkg.sv - shared constants and types for the BEC ladder sequencer
//
// Purpose: opcode encoding, instruction field positions, FSM state encoding
// and the Montgomery-ladder register-swap helper.
// Ports: none (package).
package bec_seq_pkg;

  localparam int INSTR_WIDTH = 11;

  // Instruction layout: [10:9] op, [8:6] dst, [5:3] srcA, [2:0] srcB
  localparam int OP_HI   = 10;
  localparam int OP_LO   = 9;
  localparam int DST_HI  = 8;
  localparam int DST_LO  = 6;
  localparam int SRCA_HI = 5;
  localparam int SRCA_LO = 3;
  localparam int SRCB_HI = 2;
  localparam int SRCB_LO = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SQR = 2'b10,
    OP_END = 2'b11
  } op_e;

  // S_LATCH covers the single cycle of ROM read latency after S_FETCH.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_FETCH  = 4'd2,
    S_LATCH  = 4'd3,
    S_ISSUE  = 4'd4,
    S_WAIT   = 4'd5,
    S_ADV    = 4'd6,
    S_ENDBIT = 4'd7,
    S_ERR    = 4'd8
  } state_e;

  // Ladder swap: registers 0..3 form pairs (0,1) and (2,3) that exchange
  // roles when the key bit is 1; registers 4..7 are scratch and never move.
  function automatic logic [2:0] swap_idx(input logic [2:0] r, input logic swap);
    return (swap && !r[2]) ? {r[2:1], ~r[0]} : r;
  endfunction

endpackage

// File: rtl/bec_seq_watchdog.sv
// rtl/bec_seq_watchdog.sv - result-wait watchdog for the BEC ladder sequencer
//
// Purpose: counts cycles while enabled and flags expiry on the TIMEOUT-th
// enabled cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr_i      hold the count at zero
//   en_i       count this cycle
//   expire_o   high during the TIMEOUT-th consecutive enabled cycle
module bec_seq_watchdog #(
  parameter int TIMEOUT = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the number of enabled cycles already elapsed, so the
  // TIMEOUT-th enabled cycle sees TIMEOUT-1.
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bec_ladder_sequencer.sv
// rtl/bec_ladder_sequencer.sv - Montgomery-ladder microprogram sequencer for the BEC field ALU
//
// Purpose: for each scalar bit (MSB first) replays the microprogram held in
// an external ROM, issuing ADD/MUL/SQR ops with ladder-swapped register
// indices and waiting for each result before advancing.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        host pulses: begin multiplication / return to idle
//   key_bit, key_req    current scalar bit; pulse asks host for the next bit
//   prog_addr/prog_data ROM address (pc) and data (1-cycle read latency)
//   op_valid/op_ready   op issue handshake; op_code, sel_a/b/dst are the op
//   res_valid           datapath result strobe
//   bit_idx, busy, done progress status; done pulses once per scalar
//   err_timeout         sticky result-wait timeout, cleared by start or rst
module bec_ladder_sequencer
  import bec_seq_pkg::*;
#(
  parameter int KEY_BITS = 163,
  parameter int PROG_LEN = 16,
  parameter int ADDR_W   = $clog2(PROG_LEN),
  parameter int INSTR_W  = INSTR_WIDTH,
  parameter int TIMEOUT  = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               key_bit,
  output logic               key_req,
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [1:0]         op_code,
  output logic [2:0]         sel_a,
  output logic [2:0]         sel_b,
  output logic [2:0]         sel_dst,
  input  logic               res_valid,
  output logic [7:0]         bit_idx,
  output logic               busy,
  output logic               done,
  output logic               err_timeout
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        bit_idx_q;
  logic              swap_q;
  logic              op_valid_q;
  logic [1:0]        op_code_q;
  logic [2:0]        sel_a_q;
  logic [2:0]        sel_b_q;
  logic [2:0]        sel_dst_q;
  logic              key_req_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wd_expire;

  bec_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != S_WAIT),
    .en_i     (state_q == S_WAIT),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      bit_idx_q  <= '0;
      swap_q     <= 1'b0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      sel_dst_q  <= '0;
      key_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      key_req_q <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        op_valid_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_LOAD;
              bit_idx_q <= 8'(KEY_BITS - 1);
              pc_q      <= '0;
              busy_q    <= 1'b1;
              err_q     <= 1'b0;
            end
          end
          S_LOAD: begin
            swap_q  <= key_bit;
            state_q <= S_FETCH;
          end
          S_FETCH: begin
            state_q <= S_LATCH;
          end
          S_LATCH: begin
            if (prog_data[OP_HI:OP_LO] == OP_END) begin
              // key_req is raised during ENDBIT so the host has shifted the
              // next bit in by the time LOAD samples it.
              state_q   <= S_ENDBIT;
              key_req_q <= (bit_idx_q != 8'd0);
            end else begin
              op_code_q  <= prog_data[OP_HI:OP_LO];
              sel_a_q    <= swap_idx(prog_data[SRCA_HI:SRCA_LO], swap_q);
              sel_b_q    <= swap_idx(prog_data[SRCB_HI:SRCB_LO], swap_q);
              sel_dst_q  <= swap_idx(prog_data[DST_HI:DST_LO], swap_q);
              op_valid_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (op_ready) begin
              op_valid_q <= 1'b0;
              state_q    <= res_valid ? S_ADV : S_WAIT;
            end
          end
          S_WAIT: begin
            if (res_valid) begin
              state_q <= S_ADV;
            end else if (wd_expire) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          S_ADV: begin
            if (pc_q == ADDR_W'(PROG_LEN - 1)) begin
              state_q   <= S_ENDBIT;
              key_req_q <= (bit_idx_q != 8'd0);
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_ENDBIT: begin
            if (bit_idx_q == 8'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              bit_idx_q <= bit_idx_q - 8'd1;
              pc_q      <= '0;
              state_q   <= S_LOAD;
            end
          end
          S_ERR: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign key_req     = key_req_q;
  assign prog_addr   = pc_q;
  assign op_valid    = op_valid_q;
  assign op_code     = op_code_q;
  assign sel_a       = sel_a_q;
  assign sel_b       = sel_b_q;
  assign sel_dst     = sel_dst_q;
  assign bit_idx     = bit_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_bec_ladder_sequencer.sv
// tb/tb_bec_ladder_sequencer.sv - self-checking bench for bec_ladder_sequencer
module tb_bec_ladder_sequencer;

  localparam int KB = 2;
  localparam int TO = 2000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        key_bit;
  logic        key_req;
  logic [3:0]  prog_addr;
  logic [10:0] prog_data;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [2:0]  sel_a;
  logic [2:0]  sel_b;
  logic [2:0]  sel_dst;
  logic        res_valid;
  logic [7:0]  bit_idx;
  logic        busy;
  logic        done;
  logic        err_timeout;

  bec_ladder_sequencer #(
    .KEY_BITS (KB),
    .PROG_LEN (16),
    .ADDR_W   (4),
    .INSTR_W  (11),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .key_bit     (key_bit),
    .key_req     (key_req),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .sel_dst     (sel_dst),
    .res_valid   (res_valid),
    .bit_idx     (bit_idx),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with one-cycle read latency
  logic [10:0] rom [16];
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Host key shifter: first bit after start, second bit after key_req
  logic [1:0] cur_k;
  logic       key_pos;
  always @(posedge clk) begin
    if (rst) key_pos <= 1'b0;
    else if (start && !busy) key_pos <= 1'b0;
    else if (key_req) key_pos <= 1'b1;
  end
  assign key_bit = key_pos ? cur_k[0] : cur_k[1];

  int total;
  int bad;

  // scoreboard queue: {bit, op[1:0], a[2:0], b[2:0], dst[2:0]}
  logic [11:0] exp_mem [64];
  int wr_ptr;
  int rd_ptr;

  // datapath responder configuration and state
  int ready_hold;
  int res_lat;
  bit res_en;
  bit idle_ready;
  bit force_res;
  int hold_cnt;
  bit pend;
  int pend_cnt;
  bit prev_hold;
  logic [10:0] prev_fields;

  int ops_seen;
  int key_req_cnt;
  int done_cnt;
  logic [3:0] pc_max;
  int first_ov;
  logic busy1;
  logic err1;

  typedef struct {
    logic [1:0]  k;
    logic [10:0] instr;
    logic [8:0]  e1;
    logic [8:0]  e0;
    int          hold;
    int          lat;
    bit          idle_rdy;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic [1:0] op, input logic [8:0] abd);
    exp_mem[wr_ptr] = {b, op, abd};
    wr_ptr++;
  endtask

  // One cycle: responder drives op_ready/res_valid, monitor checks outputs.
  task automatic tick();
    @(negedge clk);
    res_valid = force_res;
    force_res = 1'b0;
    op_ready  = idle_ready;
    if (pend) begin
      if (pend_cnt <= 1) begin
        res_valid = 1'b1;
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (key_req) key_req_cnt++;
    if (done) done_cnt++;
    if (busy && prog_addr > pc_max) pc_max = prog_addr;
    if (op_valid) begin
      if (prev_hold) check("hold_stable", {op_code, sel_a, sel_b, sel_dst}, prev_fields);
      prev_fields = {op_code, sel_a, sel_b, sel_dst};
      if (hold_cnt < ready_hold) begin
        op_ready  = 1'b0;
        hold_cnt++;
        prev_hold = 1'b1;
      end else begin
        op_ready  = 1'b1;
        hold_cnt  = 0;
        prev_hold = 1'b0;
        ops_seen++;
        if (rd_ptr < wr_ptr) begin
          check("sb_op", {bit_idx, op_code, sel_a, sel_b, sel_dst}, {7'b0, exp_mem[rd_ptr]});
          rd_ptr++;
        end else begin
          total++;
          bad++;
          $display("FAIL sb_extra: got op 0x%0h with nothing expected", {op_code, sel_a, sel_b, sel_dst});
        end
        if (res_en) begin
          if (res_lat == 0) res_valid = 1'b1;
          else begin
            pend = 1'b1;
            pend_cnt = res_lat;
          end
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  endtask

  task automatic run_seq(input logic [1:0] k, input int budget, input bit restart);
    int cyc;
    bit fin;
    cur_k = k;
    first_ov = 0;
    fin = 1'b0;
    cyc = 0;
    pc_max = '0;
    start = 1'b1;
    while (!fin && cyc < budget) begin
      tick();
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        busy1 = busy;
        err1  = err_timeout;
      end
      if (op_valid && first_ov == 0) first_ov = cyc;
      if (done || err_timeout) fin = 1'b1;
      if (restart && cyc == 6) start = 1'b1;
    end
    check("run_finished", 32'(fin), 32'd1);
  endtask

  task automatic clear_sb();
    wr_ptr = 0;
    rd_ptr = 0;
    pend = 1'b0;
    hold_cnt = 0;
    prev_hold = 1'b0;
  endtask

  task automatic fill_rom_end();
    for (int i = 0; i < 16; i++) rom[i] = 11'b11_000_000_000;
  endtask

  initial begin
    int o0, kr0, d0, n, waits, cnt;
    total = 0; bad = 0;
    start = 0; abort = 0; op_ready = 0; res_valid = 0; cur_k = 2'b00;
    ready_hold = 0; res_lat = 0; res_en = 1; idle_ready = 0; force_res = 0;
    ops_seen = 0; key_req_cnt = 0; done_cnt = 0; pc_max = '0;
    clear_sb();
    fill_rom_end();

    //           k      instr {op,dst,a,b}         exp bit1 {a,b,d}     exp bit0 {a,b,d}  hold lat idle
    vecs[0] = '{2'b10, {2'b01,3'd4,3'd0,3'd1}, {3'd1,3'd0,3'd4}, {3'd0,3'd1,3'd4}, 0, 0, 1'b0};
    vecs[1] = '{2'b11, {2'b00,3'd2,3'd3,3'd6}, {3'd2,3'd6,3'd3}, {3'd2,3'd6,3'd3}, 5, 1, 1'b1};
    vecs[2] = '{2'b01, {2'b10,3'd7,3'd5,3'd0}, {3'd5,3'd0,3'd7}, {3'd5,3'd1,3'd7}, 0, 3, 1'b0};
    vecs[3] = '{2'b00, {2'b01,3'd1,3'd2,3'd3}, {3'd2,3'd3,3'd1}, {3'd2,3'd3,3'd1}, 2, 0, 1'b1};
    vecs[4] = '{2'b10, {2'b00,3'd0,3'd7,3'd4}, {3'd7,3'd4,3'd1}, {3'd7,3'd4,3'd0}, 0, 2, 1'b1};
    vecs[5] = '{2'b11, {2'b10,3'd3,3'd1,3'd2}, {3'd0,3'd3,3'd2}, {3'd0,3'd3,3'd2}, 5, 1, 1'b0};

    rst = 1;
    tick(); tick(); tick();
    rst = 0;
    tick();
    check("reset_outs", {busy, done, op_valid, key_req, err_timeout, prog_addr, bit_idx, op_code, sel_a, sel_b, sel_dst}, 32'd0);

    // table-driven single-instruction programs, one restart attempt mid-run
    for (int r = 0; r < 6; r++) begin
      fill_rom_end();
      rom[0] = vecs[r].instr;
      ready_hold = vecs[r].hold;
      res_lat = vecs[r].lat;
      idle_ready = vecs[r].idle_rdy;
      clear_sb();
      push(1'b1, vecs[r].instr[10:9], vecs[r].e1);
      push(1'b0, vecs[r].instr[10:9], vecs[r].e0);
      o0 = ops_seen; kr0 = key_req_cnt; d0 = done_cnt;
      run_seq(vecs[r].k, 400, r == 3);
      check($sformatf("r%0d_ops", r), 32'(ops_seen - o0), 32'd2);
      check($sformatf("r%0d_key_req", r), 32'(key_req_cnt - kr0), 32'd1);
      check($sformatf("r%0d_done", r), 32'(done_cnt - d0), 32'd1);
      check($sformatf("r%0d_drained", r), 32'(rd_ptr), 32'(wr_ptr));
      check($sformatf("r%0d_busy_end", r), 32'(busy), 32'd0);
      check($sformatf("r%0d_latency", r), 32'(first_ov), 32'd4);
      check($sformatf("r%0d_busy_load", r), 32'(busy1), 32'd1);
      tick();
    end

    // two-instruction program, keys 1 then 0
    fill_rom_end();
    rom[0] = {2'b01, 3'd4, 3'd0, 3'd1};
    rom[1] = {2'b00, 3'd5, 3'd4, 3'd2};
    ready_hold = 0; res_lat = 1; idle_ready = 0;
    clear_sb();
    push(1'b1, 2'b01, {3'd1, 3'd0, 3'd4});
    push(1'b1, 2'b00, {3'd4, 3'd3, 3'd5});
    push(1'b0, 2'b01, {3'd0, 3'd1, 3'd4});
    push(1'b0, 2'b00, {3'd4, 3'd2, 3'd5});
    o0 = ops_seen; kr0 = key_req_cnt; d0 = done_cnt;
    run_seq(2'b10, 400, 1'b0);
    check("two_ops", 32'(ops_seen - o0), 32'd4);
    check("two_key_req", 32'(key_req_cnt - kr0), 32'd1);
    check("two_done", 32'(done_cnt - d0), 32'd1);
    check("two_drained", 32'(rd_ptr), 32'(wr_ptr));
    tick();

    // full program with no END: implicit end after pc 15
    for (int i = 0; i < 16; i++) rom[i] = {2'b01, 3'(i), 3'(i + 3), 3'(i + 5)};
    clear_sb();
    for (int b = 1; b >= 0; b--)
      for (int i = 0; i < 16; i++) push(1'(b), 2'b01, {3'(i + 3), 3'(i + 5), 3'(i)});
    o0 = ops_seen; kr0 = key_req_cnt; d0 = done_cnt;
    run_seq(2'b00, 1500, 1'b0);
    check("full_ops", 32'(ops_seen - o0), 32'd32);
    check("full_pc_max", 32'(pc_max), 32'd15);
    check("full_key_req", 32'(key_req_cnt - kr0), 32'd1);
    check("full_done", 32'(done_cnt - d0), 32'd1);
    check("full_drained", 32'(rd_ptr), 32'(wr_ptr));
    tick();

    // watchdog timeout: result never returned
    fill_rom_end();
    rom[0] = {2'b01, 3'd4, 3'd0, 3'd1};
    res_en = 0; ready_hold = 0;
    clear_sb();
    push(1'b1, 2'b01, {3'd0, 3'd1, 3'd4});
    cur_k = 2'b00;
    o0 = ops_seen;
    start = 1; tick(); start = 0;
    n = 0;
    while (ops_seen == o0 && n < 20) begin tick(); n++; end
    check("to_issued", 32'(ops_seen - o0), 32'd1);
    waits = 0;
    n = 0;
    while (!err_timeout && n < TO + 20) begin
      tick();
      n++;
      if (!err_timeout) waits++;
    end
    check("to_wait_cycles", 32'(waits), 32'(TO));
    check("to_busy", 32'(busy), 32'd0);
    check("to_op_valid", 32'(op_valid), 32'd0);
    tick();
    check("to_sticky", 32'(err_timeout), 32'd1);
    res_en = 1;
    fill_rom_end();
    rom[0] = vecs[0].instr;
    clear_sb();
    push(1'b1, 2'b01, vecs[0].e1);
    push(1'b0, 2'b01, vecs[0].e0);
    run_seq(2'b10, 400, 1'b0);
    check("to_cleared_by_start", 32'(err1), 32'd0);
    check("to_rerun_drained", 32'(rd_ptr), 32'(wr_ptr));
    tick();

    // abort while waiting for a result, then a stray late result
    res_en = 0;
    clear_sb();
    push(1'b1, 2'b01, vecs[0].e1);
    cur_k = 2'b10;
    o0 = ops_seen; kr0 = key_req_cnt; d0 = done_cnt;
    start = 1; tick(); start = 0;
    n = 0;
    while (ops_seen == o0 && n < 20) begin tick(); n++; end
    tick(); tick(); tick();
    check("ab_in_wait", {busy, op_valid}, 2'b10);
    abort = 1; tick(); abort = 0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_op_valid", 32'(op_valid), 32'd0);
    force_res = 1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy || op_valid) cnt++;
    end
    check("ab_stays_idle", 32'(cnt), 32'd0);
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);
    check("ab_no_key_req", 32'(key_req_cnt - kr0), 32'd0);
    res_en = 1;
    clear_sb();

    // start and abort together from idle
    o0 = ops_seen;
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy || op_valid) cnt++;
    end
    check("sa_busy_never", 32'(cnt), 32'd0);
    check("sa_no_ops", 32'(ops_seen - o0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
